// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums frames of COUNT unsigned 8-bit products and hands off the result
// Optional build macro: PRODUCT_ACCUMULATOR_SATURATE_EN (saturating accumulator instead of wrapping)
module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int COUNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ACC, OUT} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;
  logic             take;
  logic             last;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);

  assign sum_ext  = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, in_product};
  assign ovf_next = ovf | sum_ext[ACC_W];
  assign take     = in_valid && in_ready;
  assign last     = take && (cnt == LAST);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  // Once pinned at all-ones, every later add carries again, so it stays pinned
  assign acc_next = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_next = sum_ext[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = ACC;
    end else begin
      case (state)
        ACC:     if (last) state_nx = OUT;
        OUT:     if (out_ready) state_nx = ACC;
        default: state_nx = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == OUT) begin
      if (out_ready) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end else if (take) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
      ovf <= ovf_next;
      if (last) begin
        out_sum <= acc_next;
        out_ovf <= ovf_next;
      end
    end
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the 4-bit multiplier's 8-bit `product`, forming the accumulate half of a multiply-accumulate datapath. It accepts one product per valid/ready handshake and sums a frame of `COUNT` products into an `ACC_W`-bit accumulator. It then presents the frame sum on a held valid/ready output port until it is accepted, and starts the next frame.

## Interface
- `ACC_W`, default 16: accumulator and result width; legal range ≥ 8.
- `COUNT`, default 8: products per frame; legal range ≥ 1. Internal counter width is `$clog2(COUNT+1)`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `clear`  in  1: synchronous frame abort; highest priority after reset.
- `in_valid`  in  1: `in_product` is valid.
- `in_ready`  out  1: block accepts a product this cycle.
- `in_product`  in  8: unsigned product from the multiplier.
- `out_valid`  out  1: `out_sum` and `out_ovf` are valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_sum`  out  ACC_W: frame sum.
- `out_ovf`  out  1: the frame exceeded 2^ACC_W−1 at some point.

## Operation
- Two-state FSM, `ACC` and `OUT`. Reset state is `ACC`.
- **`ACC` state**
  - `in_ready`=1 and `out_valid`=0.
  - An input handshake (`in_valid` && `in_ready`) updates `acc <= acc + in_product` (zero-extended) and `cnt <= cnt + 1`.
  - Any carry out of bit ACC_W−1 sets the sticky flag `ovf`.
  - A handshake with `cnt == COUNT−1` latches `out_sum` = acc + in_product (including that final product), latches `out_ovf` = ovf including that final add, and moves to `OUT`.
- **`OUT` state**
  - `in_ready`=0; `out_valid`=1.
  - `out_sum` and `out_ovf` are held stable while `out_ready`=0.
  - When `out_ready`=1: acc, cnt and ovf clear to 0, and the FSM returns to `ACC`.
- **`clear`** (either state)
  - acc, cnt and ovf go to 0; state goes to `ACC`; `out_valid` drops next cycle.
  - A product presented in the same cycle is discarded, even if `in_ready`=1.
  - A pending result in `OUT` is lost.
- Arithmetic is unsigned throughout, and there is no sign handling.
- With `COUNT`=1, every accepted product produces a result.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ovf`=0; acc, cnt and ovf are 0.
- `in_ready` and `out_valid` are registered state decodes. `in_ready` has no combinational dependence on `out_ready`.
- Latency: `out_valid` rises on the cycle after the final input handshake.
- Throughput: at most one product per cycle in `ACC`, followed by at least one `OUT` cycle per frame. Peak rate is COUNT products per COUNT+1 cycles.
- Output handshake in `OUT` with `out_ready`=1:
  - `in_ready` returns to 1 on the next cycle.
  - A product offered during the `OUT` cycle is not accepted.
- Upstream may hold `in_valid` high continuously. Stalls with `in_valid`=0 do not change acc or cnt.
- Reset asserted mid-frame or mid-`OUT` returns all outputs to reset values immediately, without waiting for a clock edge.

## Configuration
- Macro `PRODUCT_ACCUMULATOR_SATURATE_EN`.
  - **Undefined:** the accumulator wraps modulo 2^ACC_W.
  - **Defined:** any add that would exceed 2^ACC_W−1 yields 2^ACC_W−1, and the accumulator stays saturated for the remainder of the frame.
- `out_ovf` behaves identically in both builds.

## Test plan
- **Basic frame** (ACC_W=16, COUNT=4): products 225,225,225,225 back-to-back → `out_valid` one cycle after the 4th handshake, `out_sum`=900, `out_ovf`=0.
- **Stalls:**
  - 3,0,15,100 with `in_valid` gaps between products → `out_sum`=118.
  - `out_ready` held 0 for 5 cycles → `out_sum` stable and `in_ready`=0 throughout.
  - Next frame starts with `out_sum` built from acc=0.
- **Overflow** (ACC_W=10, COUNT=8): eight products of 225 (total 1800) → wrap build `out_sum`=776, `out_ovf`=1; saturate build `out_sum`=1023, `out_ovf`=1.
- **Clear** (COUNT=4): after 2 products of 50, pulse `clear` together with `in_valid` (product 7) → that product is dropped. The next 4 products of 10 give `out_sum`=40.
- **Reset mid-frame:**
  - Assert `rst_n`=0 asynchronously after 2 products → outputs at reset values with no clock edge needed.
  - After release, a full 4×1 frame gives `out_sum`=4.
- **COUNT=1:** continuous `in_valid`, `out_ready`=1, products 1,2,3 → results 1,2,3, each on alternate cycles.
